// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle signed divider.
package div_pkg;

  localparam int unsigned DIV_BITS = 32;
  localparam int unsigned CNT_BITS = $clog2(DIV_BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Unsigned magnitude of a two's-complement value; |MIN| wraps back to MIN, which is
  // exactly the unsigned magnitude we need.
  function automatic logic [DIV_BITS-1:0] abs_val(input logic [DIV_BITS-1:0] v);
    return v[DIV_BITS-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the partial
// remainder and produces one quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned W = DIV_BITS
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] q,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_next,
  output logic [W-1:0] q_next
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem[W-1:0], q[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (shifted >= {1'b0, divisor}) begin
      rem_next = diff;
      q_next   = {q[W-2:0], 1'b1};
    end else begin
      rem_next = shifted;
      q_next   = {q[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider.sv
// Multicycle signed 32-bit divider: quotient on Div_Lo, remainder on Div_Hi, one quotient
// bit per cycle on magnitudes followed by a sign fix-up cycle.
module divider
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                DivCtrl,
  input  logic [DIV_BITS-1:0] Dividend,
  input  logic [DIV_BITS-1:0] Divisor,
  output logic [DIV_BITS-1:0] Div_Hi,
  output logic [DIV_BITS-1:0] Div_Lo,
  output logic                divZero,
  output logic                busy,
  output logic                done
);

  div_state_t          state_q;
  logic [DIV_BITS:0]   rem_q;
  logic [DIV_BITS-1:0] quo_q;
  logic [DIV_BITS-1:0] dsr_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic                sign_q_q;
  logic                sign_r_q;

  logic [DIV_BITS:0]   rem_next;
  logic [DIV_BITS-1:0] quo_next;

  div_step #(
    .W (DIV_BITS)
  ) u_step (
    .rem      (rem_q),
    .q        (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_next),
    .q_next   (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      Div_Hi   <= '0;
      Div_Lo   <= '0;
      divZero  <= 1'b0;
    end else begin
      divZero <= 1'b0;
      case (state_q)
        IDLE: begin
          if (DivCtrl) begin
            if (Divisor == '0) begin
              divZero <= 1'b1;
            end else begin
              quo_q    <= abs_val(Dividend);
              dsr_q    <= abs_val(Divisor);
              sign_q_q <= Dividend[DIV_BITS-1] ^ Divisor[DIV_BITS-1];
              sign_r_q <= Dividend[DIV_BITS-1];
              rem_q    <= '0;
              cnt_q    <= CNT_BITS'(DIV_BITS - 1);
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          Div_Lo  <= sign_q_q ? -quo_q : quo_q;
          Div_Hi  <= sign_r_q ? -rem_q[DIV_BITS-1:0] : rem_q[DIV_BITS-1:0];
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed, table-driven bench for the multicycle signed divider.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        DivCtrl = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic [31:0] Div_Hi;
  logic [31:0] Div_Lo;
  logic        divZero;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  divider dut (
    .clk      (clk),
    .reset    (reset),
    .DivCtrl  (DivCtrl),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Div_Hi   (Div_Hi),
    .Div_Lo   (Div_Lo),
    .divZero  (divZero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Waits (bounded) for done, counting edges since the accepting edge and busy cycles.
  task automatic wait_done(input int lat0, output int lat, output int nb);
    lat = lat0;
    nb  = 0;
    while (1) begin
      if (busy) nb++;
      if (done || lat >= 40) break;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    DivCtrl  = 1'b1;
    Dividend = a;
    Divisor  = b;
    @(posedge clk);
    @(negedge clk);
    DivCtrl = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi);
    int lat;
    int nb;
    start(a, b);
    wait_done(0, lat, nb);
    check({tag, " latency"}, 32'(lat), 32'd33);
    check({tag, " busy_cycles"}, 32'(nb), 32'd34);
    check({tag, " Div_Lo"}, Div_Lo, lo);
    check({tag, " Div_Hi"}, Div_Hi, hi);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_width"}, {31'd0, done}, 32'd0);
    check({tag, " busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int nb;
    int seen;

    vecs[0]  = '{32'd7,        32'd2,        32'd3,        32'd1};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[4]  = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    vecs[5]  = '{32'd100,      32'd7,        32'd14,       32'd2};
    vecs[6]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    vecs[7]  = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF};
    vecs[8]  = '{32'h7FFFFFFF, 32'd16,       32'h07FFFFFF, 32'd15};
    vecs[9]  = '{32'd0,        32'd5,        32'd0,        32'd0};
    vecs[10] = '{32'd5,        32'd5,        32'd1,        32'd0};
    vecs[11] = '{32'd7,        32'd2,        32'd3,        32'd1};

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("reset Div_Lo", Div_Lo, 32'd0);
    check("reset Div_Hi", Div_Hi, 32'd0);
    check("reset flags", {29'd0, divZero, busy, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
    end

    // Divide by zero with Div_Hi/Div_Lo holding 1/3 from the last vector
    @(negedge clk);
    DivCtrl = 1'b1;
    Dividend = 32'd42;
    Divisor = 32'd0;
    @(posedge clk);
    #1;
    check("dz pulse", {31'd0, divZero}, 32'd1);
    check("dz busy_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    DivCtrl = 1'b0;
    @(posedge clk);
    #1;
    check("dz pulse_end", {31'd0, divZero}, 32'd0);
    check("dz Div_Lo_hold", Div_Lo, 32'd3);
    check("dz Div_Hi_hold", Div_Hi, 32'd1);

    // Start while busy is ignored
    start(32'd100, 32'd7);
    repeat (9) @(negedge clk);
    DivCtrl = 1'b1;
    Dividend = 32'd9;
    Divisor = 32'd3;
    @(negedge clk);
    DivCtrl = 1'b0;
    wait_done(10, lat, nb);
    check("ign latency", 32'(lat), 32'd33);
    check("ign Div_Lo", Div_Lo, 32'd14);
    check("ign Div_Hi", Div_Hi, 32'd2);
    @(posedge clk);
    @(negedge clk);
    check("ign idle", {30'd0, busy, done}, 32'd0);

    // Reset mid-operation
    start(32'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst Div_Lo", Div_Lo, 32'd0);
    check("mid_rst Div_Hi", Div_Hi, 32'd0);
    check("mid_rst flags", {29'd0, divZero, busy, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("mid_rst no_done", 32'(seen), 32'd0);
    run_div("post_rst", 32'd9, 32'd3, 32'd3, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
